frame_buffer: RTL and testbench

//  Double-buffered 16-bit framebuffer directly downstream of the GPU pixel writer.
//  - Accepts single-pixel writes (fb_x, fb_y, fb_color, fb_write) into the back buffer.
//  - Scans the front buffer out to the video timing generator, integer-upscaled by 2^SCALE_LOG2.
//  - Swaps front and back buffers on request, synchronised to frame start.

---
 rtl/frame_buffer_pkg.sv | 30 +++
 rtl/frame_buffer_if.sv | 10 +
 rtl/frame_buffer_dpram.sv | 45 ++++
 rtl/frame_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_frame_buffer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared constants, types and helpers for the double-buffered framebuffer.
package frame_buffer_pkg;

    // Framebuffer geometry and scanout upscale.
    localparam int FB_WIDTH    = 160;
    localparam int FB_HEIGHT   = 120;
    localparam int SCALE_LOG2  = 2;
    localparam int PIXEL_COUNT = FB_WIDTH * FB_HEIGHT;

    // Colour word layout: R[15:11] G[10:6] B[5:1] A[0].
    localparam int COLOR_R_MSB = 15;
    localparam int COLOR_R_LSB = 11;
    localparam int COLOR_G_MSB = 10;
    localparam int COLOR_G_LSB = 6;
    localparam int COLOR_B_MSB = 5;
    localparam int COLOR_B_LSB = 1;
    localparam int ALPHA_BIT   = 0;

    // Buffer swap controller states.
    typedef enum logic [0:0] {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_e;

    // Widen a 5-bit channel to 8 bits by replicating its top bits.
    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

endpackage

// File: rtl/frame_buffer_if.sv
// Single-pixel write bus from the GPU pixel writer into the framebuffer.
interface frame_buffer_if;
    logic [7:0]  fb_x;
    logic [7:0]  fb_y;
    logic [15:0] fb_color;
    logic        fb_write;

    modport master (output fb_x, output fb_y, output fb_color, output fb_write);
    modport slave  (input  fb_x, input  fb_y, input  fb_color, input  fb_write);
endinterface

// File: rtl/frame_buffer_dpram.sv
// Simple dual-port RAM: one write port, one read port with a registered address.
module frame_buffer_dpram
    import frame_buffer_pkg::*;
#(
    parameter int DEPTH = PIXEL_COUNT,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    raddr_q;
    logic [AW-1:0]    raddr_d;

    // Next read address is taken straight from the requester.
    always_comb begin
        raddr_d = raddr;
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read address register, the first scanout pipeline stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            raddr_q <= {AW{1'b0}};
        end else begin
            raddr_q <= raddr_d;
        end
    end

    assign rdata = mem_q[raddr_q];

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered 16-bit framebuffer: pixel writes into the back buffer,
// upscaled scanout of the front buffer, frame-synchronous buffer swap.
module frame_buffer
    import frame_buffer_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    frame_buffer_if.slave  wr,
    input  logic           swap_req,
    output logic           swap_pending,
    output logic           front_sel,
    input  logic [9:0]     disp_x,
    input  logic [9:0]     disp_y,
    input  logic           disp_de,
    input  logic           disp_frame_start,
    output logic [7:0]     out_r,
    output logic [7:0]     out_g,
    output logic [7:0]     out_b,
    output logic           out_de
);

    localparam int AW = $clog2(PIXEL_COUNT);

    // Swap controller state.
    swap_state_e state_q, state_d;
    logic        front_sel_q, front_sel_d;
    logic        swap_req_q, swap_req_d;
    logic        swap_rise_s;

    // Write path.
    logic          wr_in_range_s;
    logic [15:0]   wr_index_s;
    logic [AW-1:0] wr_addr_s;
    logic          we0_s, we1_s;

    // Scanout stage 1.
    logic [9:0]    sx_s, sy_s;
    logic          rd_in_range_s;
    logic [15:0]   rd_index_s;
    logic [AW-1:0] rd_addr_s;
    logic          de_p1_q, de_p1_d;
    logic          valid_p1_q, valid_p1_d;
    logic          sel_p1_q, sel_p1_d;

    // Scanout stage 2.
    logic [15:0]   rdata0_s, rdata1_s, pixel_s;
    logic [7:0]    out_r_q, out_r_d;
    logic [7:0]    out_g_q, out_g_d;
    logic [7:0]    out_b_q, out_b_d;
    logic          out_de_q, out_de_d;

    // Bits that are deliberately not consumed (alpha is stored but never displayed).
    logic          unused_bits_s;

    // Swap request edge detection and next-state logic for the swap controller.
    always_comb begin
        swap_req_d  = swap_req;
        swap_rise_s = swap_req && !swap_req_q;
        state_d     = state_q;
        front_sel_d = front_sel_q;
        case (state_q)
            SWAP_IDLE: begin
                if (swap_rise_s && disp_frame_start) begin
                    // Request and frame start coincide: swap immediately.
                    state_d     = SWAP_IDLE;
                    front_sel_d = !front_sel_q;
                end else if (swap_rise_s) begin
                    state_d = SWAP_PENDING;
                end else begin
                    state_d = SWAP_IDLE;
                end
            end
            SWAP_PENDING: begin
                // Further request edges are absorbed until the frame boundary.
                if (disp_frame_start) begin
                    state_d     = SWAP_IDLE;
                    front_sel_d = !front_sel_q;
                end else begin
                    state_d = SWAP_PENDING;
                end
            end
            default: begin
                state_d     = SWAP_IDLE;
                front_sel_d = front_sel_q;
            end
        endcase
    end

    // Swap controller registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= SWAP_IDLE;
            front_sel_q <= 1'b0;
            swap_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            swap_req_q  <= swap_req_d;
        end
    end

    assign swap_pending = (state_q == SWAP_PENDING);
    assign front_sel    = front_sel_q;

    // Write address and per-buffer write enables; the back buffer follows the current front_sel.
    always_comb begin
        wr_in_range_s = (16'(wr.fb_x) < 16'(FB_WIDTH)) && (16'(wr.fb_y) < 16'(FB_HEIGHT));
        wr_index_s    = 16'(wr.fb_y) * 16'(FB_WIDTH) + 16'(wr.fb_x);
        if (wr_in_range_s) begin
            wr_addr_s = wr_index_s[AW-1:0];
        end else begin
            wr_addr_s = {AW{1'b0}};
        end
        we0_s = wr.fb_write && wr_in_range_s && front_sel_q;
        we1_s = wr.fb_write && wr_in_range_s && !front_sel_q;
    end

    // Downscale display coordinates to framebuffer space and form the read address.
    always_comb begin
        sx_s          = disp_x >> SCALE_LOG2;
        sy_s          = disp_y >> SCALE_LOG2;
        rd_in_range_s = (sx_s < 10'(FB_WIDTH)) && (sy_s < 10'(FB_HEIGHT));
        rd_index_s    = 16'(sy_s) * 16'(FB_WIDTH) + 16'(sx_s);
        if (rd_in_range_s) begin
            rd_addr_s = rd_index_s[AW-1:0];
        end else begin
            rd_addr_s = {AW{1'b0}};
        end
        de_p1_d    = disp_de;
        valid_p1_d = disp_de && rd_in_range_s;
        // Reads issued in a swap cycle already see the new front buffer.
        sel_p1_d   = front_sel_d;
    end

    frame_buffer_dpram #(
        .DEPTH (PIXEL_COUNT),
        .WIDTH (16)
    ) u_buf0 (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we0_s),
        .waddr (wr_addr_s),
        .wdata (wr.fb_color),
        .raddr (rd_addr_s),
        .rdata (rdata0_s)
    );

    frame_buffer_dpram #(
        .DEPTH (PIXEL_COUNT),
        .WIDTH (16)
    ) u_buf1 (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we1_s),
        .waddr (wr_addr_s),
        .wdata (wr.fb_color),
        .raddr (rd_addr_s),
        .rdata (rdata1_s)
    );

    // Select the front buffer's word and expand it to 8-bit channels, blanking invalid pixels.
    always_comb begin
        if (sel_p1_q) begin
            pixel_s = rdata1_s;
        end else begin
            pixel_s = rdata0_s;
        end
        out_de_d = de_p1_q;
        if (valid_p1_q) begin
            out_r_d = expand5(pixel_s[COLOR_R_MSB:COLOR_R_LSB]);
            out_g_d = expand5(pixel_s[COLOR_G_MSB:COLOR_G_LSB]);
            out_b_d = expand5(pixel_s[COLOR_B_MSB:COLOR_B_LSB]);
        end else begin
            out_r_d = 8'd0;
            out_g_d = 8'd0;
            out_b_d = 8'd0;
        end
    end

    // Scanout pipeline registers (stage 1 flags and stage 2 colour outputs).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            de_p1_q    <= 1'b0;
            valid_p1_q <= 1'b0;
            sel_p1_q   <= 1'b0;
            out_r_q    <= 8'd0;
            out_g_q    <= 8'd0;
            out_b_q    <= 8'd0;
            out_de_q   <= 1'b0;
        end else begin
            de_p1_q    <= de_p1_d;
            valid_p1_q <= valid_p1_d;
            sel_p1_q   <= sel_p1_d;
            out_r_q    <= out_r_d;
            out_g_q    <= out_g_d;
            out_b_q    <= out_b_d;
            out_de_q   <= out_de_d;
        end
    end

    assign out_r  = out_r_q;
    assign out_g  = out_g_q;
    assign out_b  = out_b_q;
    assign out_de = out_de_q;

    assign unused_bits_s = ^{pixel_s[ALPHA_BIT], wr_index_s[15:AW], rd_index_s[15:AW]};

endmodule

// File: tb/tb_frame_buffer.sv
// Self-checking bench for frame_buffer: directed scenarios plus randomized traffic
// compared against a behavioural model of the two buffers and the swap rules.
module tb_frame_buffer;
    import frame_buffer_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       swap_req;
    logic       swap_pending;
    logic       front_sel;
    logic [9:0] disp_x, disp_y;
    logic       disp_de, disp_frame_start;
    logic [7:0] out_r, out_g, out_b;
    logic       out_de;

    frame_buffer_if wr_bus ();

    always #5 clk = ~clk;

    frame_buffer dut (
        .clk              (clk),
        .rstn             (rstn),
        .wr               (wr_bus),
        .swap_req         (swap_req),
        .swap_pending     (swap_pending),
        .front_sel        (front_sel),
        .disp_x           (disp_x),
        .disp_y           (disp_y),
        .disp_de          (disp_de),
        .disp_frame_start (disp_frame_start),
        .out_r            (out_r),
        .out_g            (out_g),
        .out_b            (out_b),
        .out_de           (out_de)
    );

    // Reference model state.
    logic [15:0] m_mem   [2][PIXEL_COUNT];
    bit          m_known [2][PIXEL_COUNT];
    bit          m_front, m_pending, m_prev_req;
    bit          pipe_de, pipe_known;
    logic [23:0] pipe_rgb;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_rgb(input logic [15:0] c);
        int r5, g5, b5;
        r5 = (int'(c) >> 11) & 31;
        g5 = (int'(c) >> 6) & 31;
        b5 = (int'(c) >> 1) & 31;
        return {8'(r5 * 8 + r5 / 4), 8'(g5 * 8 + g5 / 4), 8'(b5 * 8 + b5 / 4)};
    endfunction

    task automatic model_reset();
        m_front    = 1'b0;
        m_pending  = 1'b0;
        m_prev_req = 1'b0;
        pipe_de    = 1'b0;
        pipe_known = 1'b1;
        pipe_rgb   = 24'd0;
    endtask

    // One clock: update the model with this cycle's inputs, then compare outputs.
    task automatic step();
        int          idx, sx, sy, back;
        bit          rise, exp_de, exp_known;
        logic [23:0] exp_rgb;
        @(posedge clk);
        back = m_front ? 0 : 1;
        if (wr_bus.fb_write && int'(wr_bus.fb_x) < FB_WIDTH && int'(wr_bus.fb_y) < FB_HEIGHT) begin
            idx = int'(wr_bus.fb_y) * FB_WIDTH + int'(wr_bus.fb_x);
            m_mem[back][idx]   = wr_bus.fb_color;
            m_known[back][idx] = 1'b1;
        end
        rise       = swap_req && !m_prev_req;
        m_prev_req = swap_req;
        if (disp_frame_start && (m_pending || rise)) begin
            m_front   = !m_front;
            m_pending = 1'b0;
        end else if (rise) begin
            m_pending = 1'b1;
        end
        exp_de    = pipe_de;
        exp_known = pipe_known;
        exp_rgb   = pipe_rgb;
        sx = int'(disp_x) / (1 << SCALE_LOG2);
        sy = int'(disp_y) / (1 << SCALE_LOG2);
        pipe_de = disp_de;
        if (!disp_de || sx >= FB_WIDTH || sy >= FB_HEIGHT) begin
            pipe_known = 1'b1;
            pipe_rgb   = 24'd0;
        end else begin
            idx        = sy * FB_WIDTH + sx;
            pipe_known = m_known[m_front][idx];
            pipe_rgb   = ref_rgb(m_mem[m_front][idx]);
        end
        #1;
        check("front_sel", front_sel, m_front);
        check("swap_pending", swap_pending, m_pending);
        check("out_de", out_de, exp_de);
        if (exp_known) begin
            check("out_rgb", {out_r, out_g, out_b}, exp_rgb);
        end
    endtask

    task automatic write_px(input int x, input int y, input logic [15:0] c);
        wr_bus.fb_x     = 8'(x);
        wr_bus.fb_y     = 8'(y);
        wr_bus.fb_color = c;
        wr_bus.fb_write = 1'b1;
        step();
        wr_bus.fb_write = 1'b0;
    endtask

    task automatic scan_one(input int x, input int y);
        disp_x  = 10'(x);
        disp_y  = 10'(y);
        disp_de = 1'b1;
        step();
        disp_de = 1'b0;
        step();
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        disp_frame_start = 1'b1;
        step();
        disp_frame_start = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        swap_req = 1'b0;
        disp_x = 10'd0;
        disp_y = 10'd0;
        disp_de = 1'b0;
        disp_frame_start = 1'b0;
        wr_bus.fb_x = 8'd0;
        wr_bus.fb_y = 8'd0;
        wr_bus.fb_color = 16'd0;
        wr_bus.fb_write = 1'b0;
        model_reset();
        #2;
        check("rst_front_sel", front_sel, 32'd0);
        check("rst_swap_pending", swap_pending, 32'd0);
        check("rst_out_de", out_de, 32'd0);
        check("rst_out_rgb", {out_r, out_g, out_b}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step();

        // Red pixel at (3,2) into back buffer, swap, scan the 4x4 upscaled block.
        write_px(3, 2, 16'hF801);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("t1_pending_set", swap_pending, 32'd1);
        disp_frame_start = 1'b1;
        step();
        disp_frame_start = 1'b0;
        check("t1_front_after_swap", front_sel, 32'd1);
        check("t1_pending_clear", swap_pending, 32'd0);
        for (int y = 8; y < 12; y++) begin
            for (int x = 12; x < 16; x++) begin
                disp_x  = 10'(x);
                disp_y  = 10'(y);
                disp_de = 1'b1;
                step();
            end
        end
        disp_de = 1'b0;
        step();
        scan_one(13, 9);
        check("t1_red_r", out_r, 32'hFF);
        check("t1_red_g", out_g, 32'h00);
        check("t1_red_b", out_b, 32'h00);
        check("t1_red_de", out_de, 32'd1);

        // Out-of-range writes are dropped, not wrapped onto (40,6).
        write_px(0, 0, 16'h07C0);
        write_px(40, 6, 16'h003E);
        write_px(200, 5, 16'hFFFF);
        write_px(5, 130, 16'hFFFF);
        do_swap();
        check("t2_front", front_sel, 32'd0);
        scan_one(1, 2);
        check("t2_origin_rgb", {out_r, out_g, out_b}, 32'h00FF00);
        scan_one(160, 24);
        check("t2_nowrap_rgb", {out_r, out_g, out_b}, 32'h0000FF);

        // One swap for a burst of request edges.
        swap_req = 1'b1; step();
        swap_req = 1'b0; step();
        swap_req = 1'b1; step();
        swap_req = 1'b0; step();
        swap_req = 1'b1; step();
        swap_req = 1'b0; step();
        swap_req = 1'b1; step();
        check("t3_pending_held", swap_pending, 32'd1);
        check("t3_front_before", front_sel, 32'd0);
        swap_req = 1'b0;
        disp_frame_start = 1'b1;
        step();
        disp_frame_start = 1'b0;
        check("t3_front_toggled", front_sel, 32'd1);
        check("t3_pending_clear", swap_pending, 32'd0);
        step();
        disp_frame_start = 1'b1;
        step();
        disp_frame_start = 1'b0;
        check("t3_idle_fs_no_swap", front_sel, 32'd1);

        // Request edge coinciding with frame start swaps at once.
        swap_req = 1'b1;
        disp_frame_start = 1'b1;
        step();
        swap_req = 1'b0;
        disp_frame_start = 1'b0;
        check("t4_front_toggled", front_sel, 32'd0);
        check("t4_pending_never", swap_pending, 32'd0);
        step();
        check("t4_pending_after", swap_pending, 32'd0);

        // Write and read in the toggle cycle both target the new front buffer.
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        disp_frame_start = 1'b1;
        wr_bus.fb_x = 8'd7;
        wr_bus.fb_y = 8'd7;
        wr_bus.fb_color = 16'h5555;
        wr_bus.fb_write = 1'b1;
        disp_x = 10'd28;
        disp_y = 10'd28;
        disp_de = 1'b1;
        step();
        disp_frame_start = 1'b0;
        wr_bus.fb_write = 1'b0;
        disp_de = 1'b0;
        step();
        check("t5_front", front_sel, 32'd1);
        check("t5_same_cycle_rgb", {out_r, out_g, out_b}, 32'h52AD52);
        scan_one(29, 30);
        check("t5_next_scan_rgb", {out_r, out_g, out_b}, 32'h52AD52);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            wr_bus.fb_write  = 1'($urandom_range(0, 1));
            wr_bus.fb_x      = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 11));
            wr_bus.fb_y      = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 11));
            wr_bus.fb_color  = 16'($urandom);
            swap_req         = ($urandom_range(0, 3) == 0);
            disp_frame_start = ($urandom_range(0, 9) == 0);
            disp_de          = ($urandom_range(0, 3) != 0);
            disp_x           = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 47));
            disp_y           = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 47));
            step();
        end
        wr_bus.fb_write  = 1'b0;
        swap_req         = 1'b0;
        disp_frame_start = 1'b0;
        disp_de          = 1'b0;
        step();

        // Asynchronous reset mid-frame with a swap pending and active display.
        swap_req = 1'b1;
        disp_x   = 10'd0;
        disp_y   = 10'd0;
        disp_de  = 1'b1;
        step();
        step();
        check("t6_pending_pre", swap_pending, 32'd1);
        check("t6_out_de_pre", out_de, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_front_rst", front_sel, 32'd0);
        check("t6_pending_rst", swap_pending, 32'd0);
        check("t6_out_de_rst", out_de, 32'd0);
        check("t6_out_rgb_rst", {out_r, out_g, out_b}, 32'd0);
        model_reset();
        swap_req = 1'b0;
        disp_de  = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (4) step();
        scan_one(28, 28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
